// File: rtl/alu_issue_stage_pkg.sv
// Shared types and constants for the ALU issue stage: ALU op codes, RV32I opcodes
// and the decoded-entry record passed from the decoder to the output register.
package alu_issue_stage_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  typedef struct packed {
    logic [31:0] opda;
    logic [31:0] opdb;
    logic [3:0]  op_sel;
    logic [4:0]  rd;
    logic        we;
    logic        illegal;
  } issue_t;

  // alt selects SUB for funct3 000 and SRA for funct3 101; ignored elsewhere.
  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Bus between the upstream register-read stage, the bypass source and the ALU.
// The slave modport is the issue stage itself; master is whoever drives it.
interface alu_issue_stage_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] opdA;
  logic [31:0] opdB;
  logic [3:0]  op_sel;
  logic [4:0]  out_rd;
  logic        out_we;
  logic        illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data,
    input  fwd_valid, fwd_rd, fwd_data,
    input  out_ready,
    output in_ready, out_valid, opdA, opdB, op_sel, out_rd, out_we, illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data,
    output fwd_valid, fwd_rd, fwd_data,
    output out_ready,
    input  in_ready, out_valid, opdA, opdB, op_sel, out_rd, out_we, illegal
  );

endinterface

// File: rtl/alu_issue_decode.sv
// Combinational RV32I decoder for OP, OP-IMM, LUI and AUIPC; everything else is
// flagged illegal with zeroed operands and writeback suppressed.
module alu_issue_decode
  import alu_issue_stage_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  output issue_t      dec
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i;
  logic [31:0] imm_u;
  logic        is_shift;

  assign opcode   = instr[6:0];
  assign f3       = instr[14:12];
  assign f7       = instr[31:25];
  assign imm_i    = {{20{instr[31]}}, instr[31:20]};
  assign imm_u    = {instr[31:12], 12'b0};
  assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

  always_comb begin
    logic legal;
    legal       = 1'b0;
    dec         = '0;
    dec.op_sel  = ALU_ADD;
    dec.rd      = instr[11:7];
    case (opcode)
      OPC_OP: begin
        legal = (f7 == 7'b0) || ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
        if (legal) begin
          dec.opda   = rs1_val;
          dec.opdb   = rs2_val;
          dec.op_sel = alu_op(f3, f7 == F7_ALT);
        end
      end
      OPC_OP_IMM: begin
        // funct3 000 has no SUB form, so alt is only honoured on the right shift.
        if (f3 == 3'b001)      legal = (f7 == 7'b0);
        else if (f3 == 3'b101) legal = (f7 == 7'b0) || (f7 == F7_ALT);
        else                   legal = 1'b1;
        if (legal) begin
          dec.opda   = rs1_val;
          dec.opdb   = is_shift ? {27'b0, instr[24:20]} : imm_i;
          dec.op_sel = alu_op(f3, (f3 == 3'b101) && (f7 == F7_ALT));
        end
      end
      OPC_LUI: begin
        legal    = 1'b1;
        dec.opdb = imm_u;
      end
      OPC_AUIPC: begin
        legal    = 1'b1;
        dec.opda = pc;
        dec.opdb = imm_u;
      end
      default: legal = 1'b0;
    endcase
    dec.illegal = !legal;
    dec.we      = legal && (dec.rd != 5'd0);
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage in front of the ALU: optional bypass (define FORWARD_EN), decode,
// and a single-entry valid/ready output register with flush.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  alu_issue_stage_if.slave  bus
);

  localparam logic [31:0] reset_pc_unused = RESET_PC;

  if (XLEN != 32) begin : g_xlen_check
    $error("alu_issue_stage supports XLEN=32 only");
  end

  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  issue_t      dec;
  issue_t      held;
  logic        out_valid_q;
  logic        accept;

`ifdef FORWARD_EN
  logic [4:0] rs1_idx;
  logic [4:0] rs2_idx;
  logic       fwd_hit;

  assign rs1_idx = bus.in_instr[19:15];
  assign rs2_idx = bus.in_instr[24:20];
  assign fwd_hit = bus.fwd_valid && (bus.fwd_rd != 5'd0);
  assign rs1_val = (fwd_hit && (bus.fwd_rd == rs1_idx)) ? bus.fwd_data : bus.in_rs1_data;
  assign rs2_val = (fwd_hit && (bus.fwd_rd == rs2_idx)) ? bus.fwd_data : bus.in_rs2_data;
`else
  logic fwd_unused;

  assign fwd_unused = ^{bus.fwd_valid, bus.fwd_rd, bus.fwd_data};
  assign rs1_val    = bus.in_rs1_data;
  assign rs2_val    = bus.in_rs2_data;
`endif

  alu_issue_decode u_decode (
    .instr   (bus.in_instr),
    .pc      (bus.in_pc),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val),
    .dec     (dec)
  );

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // Flush wins over a same-cycle accept; a consume without a new accept empties the slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             out_valid_q <= 1'b0;
    else if (flush)      out_valid_q <= 1'b0;
    else if (accept)     out_valid_q <= 1'b1;
    else if (bus.out_ready) out_valid_q <= 1'b0;
  end

  // Payload loads on any accept, flushed or not; it is don't-care while invalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held        <= '0;
      held.op_sel <= ALU_ADD;
    end else if (accept) begin
      held <= dec;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.opdA      = held.opda;
  assign bus.opdB      = held.opdb;
  assign bus.op_sel    = held.op_sel;
  assign bus.out_rd    = held.rd;
  assign bus.out_we    = held.we;
  assign bus.illegal   = held.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage; forwarding expectations
// follow whether FORWARD_EN is defined for the build.
module tb_alu_issue_stage;
  import alu_issue_stage_pkg::*;

  logic clk;
  logic rst;
  logic flush;
  int   checks;
  int   failures;

  alu_issue_stage_if bus ();

  alu_issue_stage #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_ADDI  = 32'hFFF00093;
  localparam logic [31:0] I_SRAI  = 32'h4030D113;
  localparam logic [31:0] I_SUB   = 32'h407302B3;
  localparam logic [31:0] I_LUI   = 32'h12345237;
  localparam logic [31:0] I_AUIPC = 32'hABCDE297;
  localparam logic [31:0] I_ADDX0 = 32'h00208033;
  localparam logic [31:0] I_FENCE = 32'h0000000F;
  localparam logic [31:0] I_BADF7 = 32'h022081B3;
  localparam logic [31:0] I_BADSL = 32'h40009093;

  task automatic applyStimulus(input logic valid, input logic [31:0] instr,
                               input logic [31:0] pc, input logic [31:0] rs1,
                               input logic [31:0] rs2);
    bus.in_valid    = valid;
    bus.in_instr    = instr;
    bus.in_pc       = pc;
    bus.in_rs1_data = rs1;
    bus.in_rs2_data = rs2;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    flush         = 1'b0;
    bus.out_ready = 1'b1;
    bus.fwd_valid = 1'b0;
    bus.fwd_rd    = 5'd0;
    bus.fwd_data  = 32'h0;
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    #12;

    checkOutput("rst_valid",   {31'b0, bus.out_valid}, 32'd0);
    checkOutput("rst_opdA",    bus.opdA, 32'd0);
    checkOutput("rst_opdB",    bus.opdB, 32'd0);
    checkOutput("rst_op_sel",  {28'b0, bus.op_sel}, {28'b0, ALU_ADD});
    checkOutput("rst_rd",      {27'b0, bus.out_rd}, 32'd0);
    checkOutput("rst_we",      {31'b0, bus.out_we}, 32'd0);
    checkOutput("rst_illegal", {31'b0, bus.illegal}, 32'd0);
    checkOutput("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    rst = 1'b0;

    applyStimulus(1'b1, I_ADD, 32'h0, 32'd5, 32'd7);
    tick();
    checkOutput("add_valid",  {31'b0, bus.out_valid}, 32'd1);
    checkOutput("add_opdA",   bus.opdA, 32'd5);
    checkOutput("add_opdB",   bus.opdB, 32'd7);
    checkOutput("add_op_sel", {28'b0, bus.op_sel}, {28'b0, ALU_ADD});
    checkOutput("add_rd",     {27'b0, bus.out_rd}, 32'd3);
    checkOutput("add_we",     {31'b0, bus.out_we}, 32'd1);

    applyStimulus(1'b1, I_ADDI, 32'h0, 32'h0, 32'h0);
    tick();
    checkOutput("addi_valid",  {31'b0, bus.out_valid}, 32'd1);
    checkOutput("addi_opdB",   bus.opdB, 32'hFFFFFFFF);
    checkOutput("addi_op_sel", {28'b0, bus.op_sel}, {28'b0, ALU_ADD});
    checkOutput("addi_rd",     {27'b0, bus.out_rd}, 32'd1);

    applyStimulus(1'b1, I_SRAI, 32'h0, 32'h80, 32'h0);
    tick();
    checkOutput("srai_op_sel", {28'b0, bus.op_sel}, {28'b0, ALU_SRA});
    checkOutput("srai_opdB",   bus.opdB, 32'd3);
    checkOutput("srai_opdA",   bus.opdA, 32'h80);
    checkOutput("srai_rd",     {27'b0, bus.out_rd}, 32'd2);

    bus.out_ready = 1'b0;
    applyStimulus(1'b1, I_SUB, 32'h0, 32'd100, 32'd30);
    #1;
    checkOutput("stall_in_ready", {31'b0, bus.in_ready}, 32'd0);
    tick();
    checkOutput("stall_valid",  {31'b0, bus.out_valid}, 32'd1);
    checkOutput("stall_op_sel", {28'b0, bus.op_sel}, {28'b0, ALU_SRA});
    checkOutput("stall_opdB",   bus.opdB, 32'd3);
    checkOutput("stall_rd",     {27'b0, bus.out_rd}, 32'd2);
    bus.out_ready = 1'b1;
    #1;
    checkOutput("release_in_ready", {31'b0, bus.in_ready}, 32'd1);
    tick();
    checkOutput("sub_op_sel", {28'b0, bus.op_sel}, {28'b0, ALU_SUB});
    checkOutput("sub_opdA",   bus.opdA, 32'd100);
    checkOutput("sub_opdB",   bus.opdB, 32'd30);
    checkOutput("sub_rd",     {27'b0, bus.out_rd}, 32'd5);

    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    tick();
    checkOutput("drain_valid", {31'b0, bus.out_valid}, 32'd0);

    applyStimulus(1'b1, I_LUI, 32'h0, 32'hDEAD, 32'hBEEF);
    tick();
    checkOutput("lui_opdA", bus.opdA, 32'd0);
    checkOutput("lui_opdB", bus.opdB, 32'h12345000);
    checkOutput("lui_rd",   {27'b0, bus.out_rd}, 32'd4);
    checkOutput("lui_we",   {31'b0, bus.out_we}, 32'd1);

    applyStimulus(1'b1, I_AUIPC, 32'h100, 32'hDEAD, 32'hBEEF);
    tick();
    checkOutput("auipc_opdA", bus.opdA, 32'h100);
    checkOutput("auipc_opdB", bus.opdB, 32'hABCDE000);
    checkOutput("auipc_op_sel", {28'b0, bus.op_sel}, {28'b0, ALU_ADD});

    applyStimulus(1'b1, I_ADDX0, 32'h0, 32'd1, 32'd2);
    tick();
    checkOutput("x0_we",      {31'b0, bus.out_we}, 32'd0);
    checkOutput("x0_illegal", {31'b0, bus.illegal}, 32'd0);

    applyStimulus(1'b1, I_FENCE, 32'h40, 32'h55, 32'h66);
    tick();
    checkOutput("fence_illegal", {31'b0, bus.illegal}, 32'd1);
    checkOutput("fence_we",      {31'b0, bus.out_we}, 32'd0);
    checkOutput("fence_opdA",    bus.opdA, 32'd0);
    checkOutput("fence_opdB",    bus.opdB, 32'd0);
    checkOutput("fence_op_sel",  {28'b0, bus.op_sel}, {28'b0, ALU_ADD});

    applyStimulus(1'b1, I_BADF7, 32'h0, 32'd5, 32'd7);
    tick();
    checkOutput("badf7_illegal", {31'b0, bus.illegal}, 32'd1);
    checkOutput("badf7_we",      {31'b0, bus.out_we}, 32'd0);

    applyStimulus(1'b1, I_BADSL, 32'h0, 32'd5, 32'd7);
    tick();
    checkOutput("badslli_illegal", {31'b0, bus.illegal}, 32'd1);

    applyStimulus(1'b1, I_ADD, 32'h0, 32'd5, 32'd7);
    flush = 1'b1;
    tick();
    checkOutput("flush_valid", {31'b0, bus.out_valid}, 32'd0);
    flush = 1'b0;

    applyStimulus(1'b1, I_ADD, 32'h0, 32'd9, 32'd7);
    tick();
    checkOutput("pre_rst_valid", {31'b0, bus.out_valid}, 32'd1);
    bus.out_ready = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    tick();
    checkOutput("pre_rst_stall", {31'b0, bus.out_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_valid", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("async_rst_opdA",  bus.opdA, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;

`ifdef FORWARD_EN
    exp_a = 32'h1234;
    exp_b = 32'h1234;
`else
    exp_a = 32'd5;
    exp_b = 32'd7;
`endif
    bus.fwd_valid = 1'b1;
    bus.fwd_rd    = 5'd1;
    bus.fwd_data  = 32'h1234;
    applyStimulus(1'b1, I_ADD, 32'h0, 32'd5, 32'd7);
    tick();
    checkOutput("fwd_rs1_opdA", bus.opdA, exp_a);
    checkOutput("fwd_rs1_opdB", bus.opdB, 32'd7);
    bus.fwd_rd = 5'd0;
    tick();
    checkOutput("fwd_x0_opdA", bus.opdA, 32'd5);
    bus.fwd_rd = 5'd2;
    tick();
    checkOutput("fwd_rs2_opdB", bus.opdB, exp_b);
    checkOutput("fwd_rs2_opdA", bus.opdA, 32'd5);
    bus.fwd_valid = 1'b0;
    tick();
    checkOutput("fwd_off_opdB", bus.opdB, 32'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
